// File: rtl/stage_sequencer.sv
// Control FSM for the multi-cycle core: fetch, decode, exec, (mem), write, with halt and single-step.
// Optional define STAGE_TIMEOUT_EN adds a per-stage wait limit of TIMEOUT cycles that forces HALT.
module stage_sequencer #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step_mode,
    input  logic             halt_req,
    output logic             fetch_enable,
    output logic             decode_enable,
    output logic             exec_enable,
    output logic             mem_enable,
    output logic             write_enable,
    input  logic             fetch_done,
    input  logic             decode_done,
    input  logic             exec_done,
    input  logic             mem_done,
    input  logic             write_done,
    input  logic             mem_req,
    output logic [2:0]       state_id,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] instret,
    output logic             timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WRITE  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t     state, state_nxt;
    logic       mem_flag, mem_flag_nxt;
    logic       done_ok, retire, start_ok;
    logic [4:0] enable_nxt;

    assign state_id = state;

`ifdef STAGE_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_expired, timeout_hit;

    assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT - 1));
`endif

    // A done only counts in its own stage and never in the enable cycle.
    always_comb begin
        state_nxt    = state;
        mem_flag_nxt = mem_flag;
        enable_nxt   = '0;
        done_ok      = 1'b0;
        retire       = 1'b0;
        start_ok     = 1'b0;
`ifdef STAGE_TIMEOUT_EN
        timeout_hit  = 1'b0;
`endif
        case (state)
            S_FETCH:  done_ok = fetch_done  & ~fetch_enable;
            S_DECODE: done_ok = decode_done & ~decode_enable;
            S_EXEC:   done_ok = exec_done   & ~exec_enable;
            S_MEM:    done_ok = mem_done    & ~mem_enable;
            S_WRITE:  done_ok = write_done  & ~write_enable;
            default:  done_ok = 1'b0;
        endcase

        case (state)
            S_IDLE, S_HALT: begin
                start_ok = start;
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH:  if (done_ok) state_nxt = S_DECODE;
            S_DECODE: if (done_ok) begin
                state_nxt    = S_EXEC;
                mem_flag_nxt = mem_req;
            end
            S_EXEC:   if (done_ok) state_nxt = mem_flag ? S_MEM : S_WRITE;
            S_MEM:    if (done_ok) state_nxt = S_WRITE;
            S_WRITE:  if (done_ok) begin
                retire = 1'b1;
                if (halt_req)       state_nxt = S_HALT;
                else if (step_mode) state_nxt = S_IDLE;
                else                state_nxt = S_FETCH;
            end
            default:  state_nxt = S_IDLE;
        endcase

`ifdef STAGE_TIMEOUT_EN
        if (busy && !done_ok && wait_expired) begin
            state_nxt   = S_HALT;
            timeout_hit = 1'b1;
        end
`endif

        if (state_nxt != state) begin
            case (state_nxt)
                S_FETCH:  enable_nxt[0] = 1'b1;
                S_DECODE: enable_nxt[1] = 1'b1;
                S_EXEC:   enable_nxt[2] = 1'b1;
                S_MEM:    enable_nxt[3] = 1'b1;
                S_WRITE:  enable_nxt[4] = 1'b1;
                default:  enable_nxt    = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            mem_flag      <= 1'b0;
            fetch_enable  <= 1'b0;
            decode_enable <= 1'b0;
            exec_enable   <= 1'b0;
            mem_enable    <= 1'b0;
            write_enable  <= 1'b0;
            busy          <= 1'b0;
            halted        <= 1'b0;
            instret       <= '0;
        end else begin
            state         <= state_nxt;
            mem_flag      <= mem_flag_nxt;
            fetch_enable  <= enable_nxt[0];
            decode_enable <= enable_nxt[1];
            exec_enable   <= enable_nxt[2];
            mem_enable    <= enable_nxt[3];
            write_enable  <= enable_nxt[4];
            busy          <= (state_nxt != S_IDLE) && (state_nxt != S_HALT);
            halted        <= (state_nxt == S_HALT);
            if (retire) instret <= instret + CNT_W'(1);
        end
    end

`ifdef STAGE_TIMEOUT_EN
    // The wait count restarts on every state change, so it measures time spent in the current stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state_nxt != state) wait_cnt <= '0;
            else if (busy)          wait_cnt <= wait_cnt + WAIT_W'(1);
            if (timeout_hit)        timeout_err <= 1'b1;
            else if (start_ok)      timeout_err <= 1'b0;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule
